// File: rtl/instr_fetch_seq.sv
// ----------------------------------------------------------------------------
// instr_fetch_seq
//   Instruction fetch/issue sequencer for the 8-bit processor. Fetches one
//   instruction word from program memory over a req/ack handshake, presents
//   it to the control decoder for a single issue cycle, waits for the
//   datapath to finish, then advances or redirects the program counter from
//   the decoder's Jump/Beqz/Halt outputs and the datapath zero flag.
//
// Ports
//   clock, reset        : clock; synchronous active-low reset
//   start               : leave IDLE and begin fetching at pc
//   mem_req/mem_addr    : program-memory read request and address (= pc)
//   mem_ack/mem_data    : memory acknowledge and returned instruction word
//   instr               : registered instruction word
//   OPcode/BitVerificao : instr[7:5] / instr[1:0] for the control decoder
//   instr_valid         : one-cycle pulse while the instruction is issued
//   Jump/Beqz/Halt      : control decoder outputs, sampled at end of execute
//   zero, target        : datapath zero flag and jump/branch destination
//   exec_done           : datapath completed the current instruction
//   pc                  : program counter
//   halted, fault       : sticky HALTED / ERROR indications
// ----------------------------------------------------------------------------
module instr_fetch_seq #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic [7:0] instr,
  output logic [2:0] OPcode,
  output logic [1:0] BitVerificao,
  output logic       instr_valid,
  input  logic       Jump,
  input  logic       Beqz,
  input  logic       Halt,
  input  logic       zero,
  input  logic [7:0] target,
  input  logic       exec_done,
  output logic [7:0] pc,
  output logic       halted,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_HALTED,
    S_ERROR
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_pc;
  logic [7:0] r_instr;
  logic [7:0] r_cnt;

  logic [7:0] w_cnt_inc;
  logic       w_timeout;
  logic       w_redirect;

  assign w_cnt_inc  = r_cnt + 8'd1;
  // The edge that would bring the counter to TIMEOUT is the one that faults,
  // so the comparison looks at the incremented value.
  assign w_timeout  = (w_cnt_inc == TIMEOUT_C);
  assign w_redirect = Jump | (Beqz & zero);

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack)        w_next = S_ISSUE;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_ISSUE: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          if (Halt) w_next = S_HALTED;
          else      w_next = S_FETCH;
        end
      end
      S_HALTED: w_next = S_HALTED;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output decode (pure function of state)
  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    case (r_state)
      S_FETCH:  mem_req     = 1'b1;
      S_ISSUE:  instr_valid = 1'b1;
      S_HALTED: halted      = 1'b1;
      S_ERROR:  fault       = 1'b1;
      default:  ;
    endcase
  end

  // PC, instruction register and fetch timeout counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_instr <= 8'h00;
      r_cnt   <= 8'h00;
    end else begin
      if (r_state == S_FETCH) begin
        if (mem_ack) begin
          r_instr <= mem_data;
          r_cnt   <= 8'h00;
        end else begin
          r_cnt   <= w_cnt_inc;
        end
      end
      // Halt leaves pc pointing at the halting instruction.
      if ((r_state == S_EXEC) && exec_done && !Halt) begin
        if (w_redirect) r_pc <= target;
        else            r_pc <= r_pc + 8'd1;
      end
    end
  end

  assign pc           = r_pc;
  assign mem_addr     = r_pc;
  assign instr        = r_instr;
  assign OPcode       = r_instr[7:5];
  assign BitVerificao = r_instr[1:0];

endmodule
